// File: rtl/palette_pkg.sv
// Shared types and defaults for the palette arbiter: arbitration state and
// an RGB triple at the default channel width.
package palette_pkg;

   localparam int DEFAULT_IDX_W   = 4;
   localparam int DEFAULT_COLOR_W = 4;

   typedef enum logic {
      IDLE   = 1'b0,
      LOCKED = 1'b1
   } arb_state_t;

   typedef struct packed {
      logic [DEFAULT_COLOR_W-1:0] red;
      logic [DEFAULT_COLOR_W-1:0] green;
      logic [DEFAULT_COLOR_W-1:0] blue;
   } rgb_t;

endpackage

// File: rtl/palette_arbiter_rr_pick.sv
// Combinational round-robin picker: first set bit of req at or above ptr,
// wrapping modulo N, returned as a one-hot grant.
module rr_pick #(
   parameter int N     = 4,
   parameter int PTR_W = $clog2(N)
) (
   input  logic [N-1:0]     req,
   input  logic [PTR_W-1:0] ptr,
   output logic [N-1:0]     grant,
   output logic             any
);

   logic [PTR_W-1:0] idx;

   always_comb begin
      grant = '0;
      any   = 1'b0;
      idx   = '0;
      for (int k = 0; k < N; k++) begin
         idx = PTR_W'((int'(ptr) + k) % N);
         if (!any && req[idx]) begin
            grant[idx] = 1'b1;
            any        = 1'b1;
         end
      end
   end

endmodule

// File: rtl/palette_arbiter.sv
// Round-robin, burst-locked sharing of one palette ROM between N_REQ renderers,
// with a 2-stage registered lookup pipeline tagged by requester.
//
// Handshake: a lookup from requester i is accepted on a rising edge where
// req_valid[i] & req_ready[i]; req_ready may depend on req_valid in the same
// cycle, responses carry no backpressure and must always be accepted.
module palette_arbiter
   import palette_pkg::*;
#(
   parameter int N_REQ           = 4,
   parameter int IDX_W           = DEFAULT_IDX_W,
   parameter int COLOR_W         = DEFAULT_COLOR_W,
   parameter int TRANSPARENT_IDX = 0
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic                   en,
   input  logic [N_REQ-1:0]       req_valid,
   input  logic [N_REQ-1:0]       req_last,
   input  logic [N_REQ*IDX_W-1:0] req_index,
   output logic [N_REQ-1:0]       req_ready,
   output logic [IDX_W-1:0]       pal_index,
   input  logic [COLOR_W-1:0]     pal_red,
   input  logic [COLOR_W-1:0]     pal_green,
   input  logic [COLOR_W-1:0]     pal_blue,
   output logic [N_REQ-1:0]       rsp_valid,
   output logic [COLOR_W-1:0]     rsp_red,
   output logic [COLOR_W-1:0]     rsp_green,
   output logic [COLOR_W-1:0]     rsp_blue,
   output logic                   rsp_transparent,
   output logic                   busy,
   output arb_state_t             dbg_state
);

   localparam int PTR_W = $clog2(N_REQ);

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (int'(p) == N_REQ - 1) ? '0 : p + 1'b1;
   endfunction

   arb_state_t         state_q, state_d;
   logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
   logic [PTR_W-1:0]   owner_q, owner_d;
   logic               s1_v_q, s1_v_d;
   logic [PTR_W-1:0]   s1_id_q, s1_id_d;
   logic [IDX_W-1:0]   pal_index_q, pal_index_d;
   logic [N_REQ-1:0]   rsp_valid_q, rsp_valid_d;
   logic [COLOR_W-1:0] rsp_red_q, rsp_red_d;
   logic [COLOR_W-1:0] rsp_green_q, rsp_green_d;
   logic [COLOR_W-1:0] rsp_blue_q, rsp_blue_d;
   logic               rsp_transp_q, rsp_transp_d;

   logic [N_REQ-1:0]   pick_grant;
   logic               pick_any;
   logic [N_REQ-1:0]   hs_vec;
   logic               hs;
   logic [PTR_W-1:0]   hs_id;
   logic               hs_last;
   logic [IDX_W-1:0]   hs_index;

   rr_pick #(
      .N     (N_REQ),
      .PTR_W (PTR_W)
   ) u_rr_pick (
      .req   (req_valid),
      .ptr   (rr_ptr_q),
      .grant (pick_grant),
      .any   (pick_any)
   );

   // Grant and handshake decode; ready is held low during reset.
   always_comb begin
      req_ready = '0;
      hs_id     = '0;
      if (reset_n && en) begin
         if (state_q == IDLE) begin
            if (pick_any) begin
               req_ready = pick_grant;
            end
         end else begin
            req_ready[owner_q] = req_valid[owner_q];
         end
      end
      hs_vec = req_ready & req_valid;
      hs     = |hs_vec;
      for (int i = 0; i < N_REQ; i++) begin
         if (hs_vec[i]) begin
            hs_id = PTR_W'(i);
         end
      end
      hs_last  = req_last[hs_id];
      hs_index = req_index[int'(hs_id)*IDX_W +: IDX_W];
   end

   // Arbitration FSM: a non-final handshake locks onto its requester, a final
   // one releases and moves the round-robin pointer past it.
   always_comb begin
      state_d  = state_q;
      rr_ptr_d = rr_ptr_q;
      owner_d  = owner_q;
      if (hs) begin
         if (hs_last) begin
            state_d  = IDLE;
            rr_ptr_d = ptr_inc(hs_id);
         end else begin
            state_d = LOCKED;
            owner_d = hs_id;
         end
      end
   end

   // Lookup pipeline: stage 1 presents the index to the ROM, stage 2 captures colour.
   always_comb begin
      s1_v_d       = hs;
      s1_id_d      = hs ? hs_id : s1_id_q;
      pal_index_d  = hs ? hs_index : pal_index_q;
      rsp_valid_d  = '0;
      rsp_red_d    = rsp_red_q;
      rsp_green_d  = rsp_green_q;
      rsp_blue_d   = rsp_blue_q;
      rsp_transp_d = rsp_transp_q;
      if (s1_v_q) begin
         rsp_valid_d[s1_id_q] = 1'b1;
         rsp_red_d            = pal_red;
         rsp_green_d          = pal_green;
         rsp_blue_d           = pal_blue;
         rsp_transp_d         = (pal_index_q == IDX_W'(TRANSPARENT_IDX));
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q      <= IDLE;
         rr_ptr_q     <= '0;
         owner_q      <= '0;
         s1_v_q       <= 1'b0;
         s1_id_q      <= '0;
         pal_index_q  <= '0;
         rsp_valid_q  <= '0;
         rsp_red_q    <= '0;
         rsp_green_q  <= '0;
         rsp_blue_q   <= '0;
         rsp_transp_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         rr_ptr_q     <= rr_ptr_d;
         owner_q      <= owner_d;
         s1_v_q       <= s1_v_d;
         s1_id_q      <= s1_id_d;
         pal_index_q  <= pal_index_d;
         rsp_valid_q  <= rsp_valid_d;
         rsp_red_q    <= rsp_red_d;
         rsp_green_q  <= rsp_green_d;
         rsp_blue_q   <= rsp_blue_d;
         rsp_transp_q <= rsp_transp_d;
      end
   end

   assign pal_index       = pal_index_q;
   assign rsp_valid       = rsp_valid_q;
   assign rsp_red         = rsp_red_q;
   assign rsp_green       = rsp_green_q;
   assign rsp_blue        = rsp_blue_q;
   assign rsp_transparent = rsp_transp_q;
   assign busy            = (state_q == LOCKED) || s1_v_q || (|rsp_valid_q);
   assign dbg_state       = state_q;

endmodule

// File: tb/tb_palette_arbiter.sv
// Directed bench for palette_arbiter: a cycle-level reference model checked
// every cycle, plus literal expectations for the key scenarios.
module tb_palette_arbiter;
   import palette_pkg::*;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        en;
   logic [3:0]  req_valid;
   logic [3:0]  req_last;
   logic [15:0] req_index;
   logic [3:0]  req_ready;
   logic [3:0]  pal_index;
   logic [3:0]  pal_red, pal_green, pal_blue;
   logic [3:0]  rsp_valid;
   logic [3:0]  rsp_red, rsp_green, rsp_blue;
   logic        rsp_transparent;
   logic        busy;
   arb_state_t  dbg_state;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   palette_arbiter #(
      .N_REQ(4), .IDX_W(4), .COLOR_W(4), .TRANSPARENT_IDX(0)
   ) dut (
      .clk(clk), .reset_n(reset_n), .en(en),
      .req_valid(req_valid), .req_last(req_last), .req_index(req_index),
      .req_ready(req_ready), .pal_index(pal_index),
      .pal_red(pal_red), .pal_green(pal_green), .pal_blue(pal_blue),
      .rsp_valid(rsp_valid), .rsp_red(rsp_red), .rsp_green(rsp_green),
      .rsp_blue(rsp_blue), .rsp_transparent(rsp_transparent),
      .busy(busy), .dbg_state(dbg_state)
   );

   // Palette ROM stand-in: an arbitrary but distinct colour per index.
   function automatic rgb_t rom(input logic [3:0] i);
      rgb_t c;
      c.red   = i ^ 4'hA;
      c.green = i + 4'd3;
      c.blue  = ~i;
      return c;
   endfunction

   assign {pal_red, pal_green, pal_blue} = rom(pal_index);

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   // exp_q entry: [23:8] cycle the response is due, [7:4] requester, [3:0] index
   logic [23:0] exp_q[$];
   int          cyc       = 0;
   bit          m_started = 1'b0;
   bit          m_locked;
   int          m_rr, m_owner;
   bit          m_hs;
   int          m_id;
   bit          m_last;
   logic [3:0]  m_idx;
   logic [3:0]  exp_pal_idx;
   rgb_t        exp_rgb;
   bit          exp_transp;

   initial begin : model_update
      forever begin
         @(posedge clk);
         cyc++;
         if (!reset_n) begin
            m_started   = 1'b1;
            m_locked    = 1'b0;
            m_rr        = 0;
            m_owner     = 0;
            exp_q.delete();
            exp_pal_idx = '0;
            exp_rgb     = '0;
            exp_transp  = 1'b0;
         end else if (m_started) begin
            if (exp_q.size() > 0 && int'(exp_q[0][23:8]) < cyc) void'(exp_q.pop_front());
            if (m_hs) begin
               exp_q.push_back({16'(cyc + 1), 4'(m_id), m_idx});
               exp_pal_idx = m_idx;
               if (m_last) begin
                  m_locked = 1'b0;
                  m_rr     = (m_id + 1) % 4;
               end else begin
                  m_locked = 1'b1;
                  m_owner  = m_id;
               end
            end
            if (exp_q.size() > 0 && int'(exp_q[0][23:8]) == cyc) begin
               exp_rgb    = rom(exp_q[0][3:0]);
               exp_transp = (exp_q[0][3:0] == 4'd0);
            end
         end
      end
   end

   initial begin : model_compare
      logic [3:0] er;
      logic [3:0] ev;
      int         i;
      m_hs = 1'b0;
      forever begin
         @(negedge clk);
         if (m_started) begin
            er = '0;
            if (reset_n && en) begin
               if (m_locked) begin
                  er[m_owner] = req_valid[m_owner];
               end else begin
                  for (int k = 0; k < 4; k++) begin
                     i = (m_rr + k) % 4;
                     if (er == '0 && req_valid[i]) er[i] = 1'b1;
                  end
               end
            end
            ev = '0;
            if (exp_q.size() > 0 && int'(exp_q[0][23:8]) == cyc) ev[exp_q[0][7:4]] = 1'b1;
            check("m_req_ready", 32'(req_ready), 32'(er));
            check("m_pal_index", 32'(pal_index), 32'(exp_pal_idx));
            check("m_rsp_valid", 32'(rsp_valid), 32'(ev));
            check("m_rsp_rgb", 32'({rsp_red, rsp_green, rsp_blue}), 32'(exp_rgb));
            check("m_rsp_transparent", 32'(rsp_transparent), 32'(exp_transp));
            check("m_busy", 32'(busy), 32'(m_locked || (exp_q.size() > 0)));
            check("m_state", 32'(dbg_state), 32'(m_locked));
            m_hs = |(er & req_valid);
            m_id = 0;
            for (int k = 0; k < 4; k++) if (er[k]) m_id = k;
            m_last = req_last[m_id];
            m_idx  = req_index[m_id*4 +: 4];
         end
      end
   end

   // ---------------- driver ----------------
   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic drive(input logic [3:0] v, input logic [3:0] l, input logic [15:0] idx);
      req_valid = v;
      req_last  = l;
      req_index = idx;
   endtask

   initial begin : stimulus
      reset_n = 1'b0;
      en      = 1'b1;
      drive(4'b1111, 4'b1111, 16'hBA98);
      repeat (3) step();
      @(negedge clk);
      check("reset_ready", 32'(req_ready), 32'h0);
      check("reset_rsp_valid", 32'(rsp_valid), 32'h0);
      check("reset_pal_index", 32'(pal_index), 32'h0);
      check("reset_busy", 32'(busy), 32'h0);

      // Round-robin: everyone valid, single-lookup bursts.
      step();
      reset_n = 1'b1;
      for (int g = 0; g < 8; g++) begin
         @(negedge clk);
         check("rr_ready", 32'(req_ready), 32'(4'b0001 << (g % 4)));
         if (g >= 2) check("rr_rsp_valid", 32'(rsp_valid), 32'(4'b0001 << ((g - 2) % 4)));
         if (g == 2) check("rr_rsp_rgb", 32'({rsp_red, rsp_green, rsp_blue}), 32'h2B7);
         step();
      end

      // Single lookup, req0 index 5.
      drive(4'b0001, 4'b0001, 16'h0005);
      @(negedge clk);
      check("single_ready", 32'(req_ready), 32'h1);
      step();
      drive(4'b0000, 4'b0000, 16'h0000);
      @(negedge clk);
      check("single_pal_index", 32'(pal_index), 32'h5);
      step();
      @(negedge clk);
      check("single_rsp_valid", 32'(rsp_valid), 32'h1);
      check("single_rsp_rgb", 32'({rsp_red, rsp_green, rsp_blue}), 32'hF8A);

      // Burst lock on req2 with a gap, then req3 wins the next arbitration.
      step();
      drive(4'b0100, 4'b0000, 16'h0300);
      @(negedge clk);
      check("burst_ready_1", 32'(req_ready), 32'h4);
      step();
      drive(4'b0111, 4'b0000, 16'h0421);
      @(negedge clk);
      check("burst_ready_2", 32'(req_ready), 32'h4);
      step();
      drive(4'b0011, 4'b0000, 16'h0421);
      @(negedge clk);
      check("burst_gap_ready", 32'(req_ready), 32'h0);
      check("burst_gap_state", 32'(dbg_state), 32'(LOCKED));
      step();
      drive(4'b0111, 4'b0100, 16'h0521);
      @(negedge clk);
      check("burst_ready_3", 32'(req_ready), 32'h4);
      step();
      drive(4'b1011, 4'b1111, 16'h6000);
      @(negedge clk);
      check("burst_next_ready", 32'(req_ready), 32'h8);

      // Transparent index from req1.
      step();
      drive(4'b0010, 4'b0010, 16'h0000);
      @(negedge clk);
      check("transp_ready", 32'(req_ready), 32'h2);
      step();
      drive(4'b0000, 4'b0000, 16'h0000);
      step();
      @(negedge clk);
      check("transp_rsp_valid", 32'(rsp_valid), 32'h2);
      check("transp_flag", 32'(rsp_transparent), 32'h1);
      check("transp_rgb", 32'({rsp_red, rsp_green, rsp_blue}), 32'hA3F);

      // en=0 in the middle of a req3 burst.
      step();
      drive(4'b1000, 4'b0000, 16'h7000);
      @(negedge clk);
      check("en_burst_ready", 32'(req_ready), 32'h8);
      step();
      en = 1'b0;
      drive(4'b1111, 4'b0000, 16'h7000);
      @(negedge clk);
      check("en_off_ready", 32'(req_ready), 32'h0);
      check("en_off_state", 32'(dbg_state), 32'(LOCKED));
      step();
      @(negedge clk);
      check("en_off_rsp_valid", 32'(rsp_valid), 32'h8);
      check("en_off_rsp_rgb", 32'({rsp_red, rsp_green, rsp_blue}), 32'hDA8);
      check("en_off_ready_2", 32'(req_ready), 32'h0);
      step();
      en = 1'b1;
      drive(4'b1000, 4'b1000, 16'h9000);
      @(negedge clk);
      check("en_on_ready", 32'(req_ready), 32'h8);
      step();
      drive(4'b0000, 4'b0000, 16'h0000);

      // Reset one cycle after a handshake discards the lookup.
      step();
      drive(4'b0100, 4'b0100, 16'h0C00);
      @(negedge clk);
      check("rst_mid_ready", 32'(req_ready), 32'h4);
      step();
      reset_n = 1'b0;
      drive(4'b0000, 4'b0000, 16'h0000);
      @(negedge clk);
      check("rst_mid_pal_index", 32'(pal_index), 32'hC);
      step();
      reset_n = 1'b1;
      drive(4'b1111, 4'b1111, 16'h1111);
      @(negedge clk);
      check("rst_mid_rsp_valid", 32'(rsp_valid), 32'h0);
      check("rst_mid_pal_cleared", 32'(pal_index), 32'h0);
      check("rst_restart_ready", 32'(req_ready), 32'h1);
      step();
      drive(4'b0000, 4'b0000, 16'h0000);
      repeat (4) step();
      @(negedge clk);
      check("drain_busy", 32'(busy), 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
